// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result display path: FSM states, 7-segment
// codes and the digit-count helper used to validate the DIGITS parameter.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Smallest d with 10**d > 2**bits.
    function automatic int digits_needed(input int bits);
        longint lim_v;
        longint pow_v;
        int     d_v;
        lim_v = 64'sd1 <<< bits;
        pow_v = 64'sd1;
        d_v   = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow_v <= lim_v) begin
                pow_v = pow_v * 64'sd10;
                d_v   = d_v + 1;
            end else begin
                pow_v = pow_v;
            end
        end
        return d_v;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD digit to active-high 7-segment pattern; non-decimal codes go dark.
module bcd_to_seg
    import alu_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit decode
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_result_bcd.sv
// Sequential double-dabble conversion of the ALU result to BCD plus 7-segment
// drive. Optional LEAD_ZERO_BLANK_EN blanks leading zero digits on seg only.
module alu_result_bcd
    import alu_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*WIDTH-1:0]    value,
    input  logic                  ovf_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int VW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(VW + 1);

    if (DIGITS < digits_needed(VW)) begin : g_digits_check
        $error("alu_result_bcd: DIGITS too small for a %0d-bit result", VW);
    end

    conv_state_t    state_r;
    conv_state_t    next_s;
    logic [VW-1:0]  shreg_r;
    logic [BW-1:0]  scratch_r;
    logic [BW-1:0]  adj_s;
    logic [CW-1:0]  cnt_r;
    logic           ovf_q_r;
    logic           busy_r;
    logic           done_r;
    logic [BW-1:0]  bcd_r;
    logic           ovf_r;
    logic [7*DIGITS-1:0] raw_seg_s;
    logic [DIGITS-1:0]   blank_s;

    // Add-3 correction on every scratch digit of 5 or more (4-bit, carry dropped)
    always_comb begin
        adj_s = scratch_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = scratch_r[4*i +: 4];
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = SHIFT;
                end else begin
                    next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CW'(1)) begin
                    next_s = DONE;
                end else begin
                    next_s = SHIFT;
                end
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != IDLE);
            done_r  <= (state_r == DONE);
        end
    end

    // Conversion datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            ovf_q_r   <= 1'b0;
            bcd_r     <= '0;
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shreg_r   <= value;
                        scratch_r <= '0;
                        cnt_r     <= CW'(VW);
                        ovf_q_r   <= ovf_in;
                    end else begin
                        shreg_r   <= shreg_r;
                    end
                end
                SHIFT: begin
                    {scratch_r, shreg_r} <= {adj_s[BW-2:0], shreg_r, 1'b0};
                    cnt_r                <= cnt_r - CW'(1);
                end
                DONE: begin
                    bcd_r <= scratch_r;
                    ovf_r <= ovf_q_r;
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_to_seg u_seg (
            .digit (bcd_r[4*g +: 4]),
            .seg   (raw_seg_s[7*g +: 7])
        );
    end

`ifdef LEAD_ZERO_BLANK_EN
    // Blank zero digits above the most significant nonzero digit; digit 0 always shown
    always_comb begin
        logic seen_s;
        seen_s  = 1'b0;
        blank_s = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (bcd_r[4*i +: 4] != 4'd0) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            blank_s[i] = ~seen_s;
        end
    end
`else
    assign blank_s = '0;
`endif

    // Apply blanking mask to decoded segments
    always_comb begin
        seg = raw_seg_s;
        for (int i = 0; i < DIGITS; i++) begin
            if (blank_s[i]) begin
                seg[7*i +: 7] = SEG_BLANK;
            end else begin
                seg[7*i +: 7] = raw_seg_s[7*i +: 7];
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed scoreboard bench for alu_result_bcd (default WIDTH=6, DIGITS=4).
// Honours LEAD_ZERO_BLANK_EN when the same macro is defined for the build.
module tb_alu_result_bcd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] value;
    logic        ovf_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;
    logic [27:0] seg;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    logic [15:0] prev_bcd;

    alu_result_bcd #(.WIDTH(6), .DIGITS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .value  (value),
        .ovf_in (ovf_in),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .ovf    (ovf),
        .seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = 16'h0000;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] ref_seg(input logic [15:0] b);
        logic [6:0]  tbl [10];
        logic [27:0] r;
        logic        lead;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        r = 28'h0;
        lead = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (b[4*i +: 4] != 4'd0) lead = 1'b0;
            r[7*i +: 7] = tbl[b[4*i +: 4]];
`ifdef LEAD_ZERO_BLANK_EN
            if (lead && i != 0) r[7*i +: 7] = 7'h00;
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bcd"},  32'(bcd),  32'h0000);
        check({tag, "_ovf"},  32'(ovf),  32'd0);
        check({tag, "_seg"},  32'(seg),  32'(ref_seg(16'h0000)));
    endtask

    // Run one conversion; optionally pulse a second start (999) while busy.
    task automatic convert(input string tag, input int v, input logic o, input bit inject);
        exp_t e;
        int   cycles;
        int   extra;
        @(negedge clk);
        value  = 12'(v);
        ovf_in = o;
        start  = 1'b1;
        sb_q.push_back('{bcd: ref_bcd(v), ovf: o});
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (inject && cycles == 3) begin
                value  = 12'd999;
                ovf_in = 1'b1;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            if (cycles == 5) check({tag, "_hold_bcd"}, 32'(bcd), 32'(prev_bcd));
        end
        check({tag, "_latency"}, 32'(cycles), 32'd13);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_bcd"}, 32'(bcd), 32'(e.bcd));
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            check({tag, "_seg"}, 32'(seg), 32'(ref_seg(e.bcd)));
            prev_bcd = e.bcd;
        end
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            check({tag, "_no_second_done"}, 32'(extra), 32'd0);
            check({tag, "_bcd_kept"}, 32'(bcd), 32'(prev_bcd));
        end
    endtask

    initial begin
        int dones;
        total    = 0;
        bad      = 0;
        prev_bcd = 16'h0000;
        rst_n    = 1'b0;
        start    = 1'b0;
        value    = 12'd0;
        ovf_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        convert("max4095", 4095, 1'b0, 1'b0);
        convert("zero", 0, 1'b0, 1'b0);
        convert("busy_ignore", 123, 1'b0, 1'b1);
        convert("ovf_set", 3969, 1'b1, 1'b0);
        convert("ovf_clear", 3969, 1'b0, 1'b0);
        convert("mixed", 507, 1'b0, 1'b0);

        // Abort a conversion with reset five cycles in
        @(negedge clk);
        value  = 12'd3000;
        ovf_in = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        prev_bcd = 16'h0000;
        convert("after_abort", 42, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
